// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter giving NumReq requesters access to a single-port-style
// memory, with a power-up sweep that writes ClearValue to every location.
//
//   state | meaning
//   INIT  | clear sweep in progress; memory writes ClearValue at initCnt
//   RUN   | round-robin arbitration; one access granted per enabled cycle
module mem_access_arbiter #(
    parameter int BitWidth = 8,
    parameter int Depth = 16,
    parameter int NumReq = 4,
    parameter logic [BitWidth-1:0] ClearValue = '0,
    localparam int AW = $clog2(Depth)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic [NumReq-1:0]          req_valid,
    input  logic [NumReq-1:0]          req_we,
    input  logic [NumReq*AW-1:0]       req_addr,
    input  logic [NumReq*BitWidth-1:0] req_wdata,
    output logic [NumReq-1:0]          req_ready,
    output logic [NumReq-1:0]          rsp_valid,
    output logic [BitWidth-1:0]        rsp_data,
    output logic                       init_done,
    output logic                       mem_wEn,
    output logic [AW-1:0]              mem_wAddr,
    output logic [BitWidth-1:0]        mem_dIN,
    output logic                       mem_rEn,
    output logic [AW-1:0]              mem_rAddr,
    input  logic [BitWidth-1:0]        mem_dOUT
);

    localparam int PW = $clog2(NumReq);

    typedef enum logic {INIT, RUN} arbState_e;

    arbState_e         state, stateNext;
    logic [AW-1:0]     initCnt;
    logic [PW-1:0]     ptr, ptrNext;
    logic              active;
    logic              granted;
    logic [PW-1:0]     grantIdx;
    logic [NumReq-1:0] grantOH;
    logic [PW:0]       cand;

    // Combinational outputs are also gated by rst_n so a reset aborts an access at once.
    assign active    = clk_en & rst_n;
    assign req_ready = grantOH;

    always_comb begin
        grantOH  = '0;
        grantIdx = '0;
        granted  = 1'b0;
        cand     = '0;
        if (active && state == RUN) begin
            for (int k = 0; k < NumReq; k++) begin
                cand = {1'b0, ptr} + (PW+1)'(k);
                if (cand >= (PW+1)'(NumReq)) cand = cand - (PW+1)'(NumReq);
                if (!granted && req_valid[cand[PW-1:0]]) begin
                    granted  = 1'b1;
                    grantIdx = cand[PW-1:0];
                end
            end
            if (granted) grantOH[grantIdx] = 1'b1;
        end
    end

    assign ptrNext = (grantIdx == PW'(NumReq - 1)) ? '0 : grantIdx + 1'b1;

    always_comb begin
        mem_wEn   = 1'b0;
        mem_wAddr = '0;
        mem_dIN   = '0;
        mem_rEn   = 1'b0;
        mem_rAddr = '0;
        if (active) begin
            if (state == INIT) begin
                mem_wEn   = 1'b1;
                mem_wAddr = initCnt;
                mem_dIN   = ClearValue;
            end else if (granted) begin
                if (req_we[grantIdx]) begin
                    mem_wEn   = 1'b1;
                    mem_wAddr = req_addr[grantIdx*AW +: AW];
                    mem_dIN   = req_wdata[grantIdx*BitWidth +: BitWidth];
                end else begin
                    mem_rEn   = 1'b1;
                    mem_rAddr = req_addr[grantIdx*AW +: AW];
                end
            end
        end
    end

    always_comb begin
        stateNext = state;
        if (clk_en && state == INIT && initCnt == AW'(Depth - 1)) stateNext = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            initCnt   <= '0;
            ptr       <= '0;
            init_done <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (clk_en) begin
            rsp_valid <= '0;
            if (state == INIT) begin
                initCnt <= initCnt + 1'b1;
                if (stateNext == RUN) init_done <= 1'b1;
            end
            if (granted) begin
                ptr <= ptrNext;
                if (!req_we[grantIdx]) begin
                    rsp_valid <= grantOH;
                    rsp_data  <= mem_dOUT;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: clear sweep, clock-enable stalls,
// round-robin order, read latency and reset abort, against a small memory.
module tb_mem_access_arbiter;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [3:0]  req_valid;
    logic [3:0]  req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        init_done;
    logic        mem_wEn;
    logic [3:0]  mem_wAddr;
    logic [7:0]  mem_dIN;
    logic        mem_rEn;
    logic [3:0]  mem_rAddr;
    logic [7:0]  mem_dOUT;

    logic [7:0]  tbMem [16];
    int          wrCount = 0;
    int          checks = 0;
    int          errors = 0;

    mem_access_arbiter #(
        .BitWidth(8), .Depth(16), .NumReq(4), .ClearValue(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .init_done(init_done), .mem_wEn(mem_wEn),
        .mem_wAddr(mem_wAddr), .mem_dIN(mem_dIN), .mem_rEn(mem_rEn),
        .mem_rAddr(mem_rAddr), .mem_dOUT(mem_dOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dOUT = tbMem[mem_rAddr];

    always @(posedge clk) begin
        if (mem_wEn) begin
            tbMem[mem_wAddr] <= mem_dIN;
            wrCount <= wrCount + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int i, input logic v, input logic we,
                          input logic [3:0] a, input logic [7:0] d);
        req_valid[i] = v;
        req_we[i] = we;
        req_addr[i*4 +: 4] = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    logic [3:0] expOrder [5];
    int         idxOrder [5];

    initial begin
        for (int i = 0; i < 16; i++) tbMem[i] = 8'hFF;
        expOrder = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        idxOrder = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        clk_en = 1'b1;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;

        @(posedge clk); #1;
        check("rst_init_done", 32'(init_done), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_wEn", 32'(mem_wEn), 32'h0);
        rst_n = 1'b1;
        req_valid = 4'hF;

        // Clear sweep, with a three-cycle clock-enable stall at counter 5.
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    clk_en = 1'b0;
                    #1;
                    check("stall_wEn", 32'(mem_wEn), 32'h0);
                    check("stall_ready", 32'(req_ready), 32'h0);
                    @(posedge clk); #1;
                end
                check("stall_wrcount", 32'(wrCount), 32'd5);
            end
            @(negedge clk);
            clk_en = 1'b1;
            #1;
            check("init_wEn", 32'(mem_wEn), 32'h1);
            check("init_wAddr", 32'(mem_wAddr), 32'(i));
            check("init_dIN", 32'(mem_dIN), 32'h0);
            check("init_ready", 32'(req_ready), 32'h0);
            check("init_rEn", 32'(mem_rEn), 32'h0);
            @(posedge clk); #1;
            check("init_done", 32'(init_done), (i == 15) ? 32'h1 : 32'h0);
        end
        check("init_wrcount", 32'(wrCount), 32'd16);
        for (int i = 0; i < 16; i++) check("init_mem", 32'(tbMem[i]), 32'h0);

        // Requester 2 writes 0xA5 to address 3, then reads it back (pointer 0 -> 3 -> 3).
        @(negedge clk);
        req_valid = '0;
        setReq(2, 1'b1, 1'b1, 4'd3, 8'hA5);
        #1;
        check("wr_ready", 32'(req_ready), 32'b0100);
        check("wr_wEn", 32'(mem_wEn), 32'h1);
        check("wr_wAddr", 32'(mem_wAddr), 32'd3);
        check("wr_dIN", 32'(mem_dIN), 32'hA5);
        check("wr_rEn", 32'(mem_rEn), 32'h0);
        @(posedge clk); #1;
        check("wr_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        setReq(2, 1'b1, 1'b0, 4'd3, 8'h00);
        #1;
        check("rd_ready", 32'(req_ready), 32'b0100);
        check("rd_rEn", 32'(mem_rEn), 32'h1);
        check("rd_rAddr", 32'(mem_rAddr), 32'd3);
        check("rd_wEn", 32'(mem_wEn), 32'h0);
        @(posedge clk); #1;
        check("rd_rsp_valid", 32'(rsp_valid), 32'b0100);
        check("rd_rsp_data", 32'(rsp_data), 32'hA5);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("idle_ready", 32'(req_ready), 32'h0);
        check("idle_wEn", 32'(mem_wEn), 32'h0);
        check("idle_rEn", 32'(mem_rEn), 32'h0);
        check("idle_wAddr", 32'(mem_wAddr), 32'h0);
        @(posedge clk); #1;
        check("pulse_rsp_valid", 32'(rsp_valid), 32'h0);
        check("hold_rsp_data", 32'(rsp_data), 32'hA5);

        // Pointer is 3: a grant to requester 3 brings it back to 0.
        @(negedge clk);
        setReq(3, 1'b1, 1'b0, 4'd3, 8'h00);
        #1;
        check("p3_ready", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        check("p3_rsp_valid", 32'(rsp_valid), 32'b1000);

        // All four requesters writing: grants 0,1,2,3,0.
        for (int i = 0; i < 4; i++) setReq(i, 1'b1, 1'b1, 4'(8 + i), 8'(8'h10 + i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("rr_ready", 32'(req_ready), 32'(expOrder[k]));
            check("rr_wAddr", 32'(mem_wAddr), 32'(8 + idxOrder[k]));
            check("rr_dIN", 32'(mem_dIN), 32'(8'h10 + idxOrder[k]));
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) check("rr_mem", 32'(tbMem[8 + i]), 32'(8'h10 + i));

        // Pointer is 1: requester 1 reads address 9, pointer -> 2.
        @(negedge clk);
        req_valid = '0;
        setReq(1, 1'b1, 1'b0, 4'd9, 8'h00);
        #1;
        check("p1_ready", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        check("p1_rsp_valid", 32'(rsp_valid), 32'b0010);
        check("p1_rsp_data", 32'(rsp_data), 32'h11);

        // Pointer 2, only requester 1 valid: wrap-around grant, pointer -> 2 again.
        @(negedge clk);
        setReq(1, 1'b1, 1'b0, 4'd8, 8'h00);
        #1;
        check("wrap_ready", 32'(req_ready), 32'b0010);
        check("wrap_rAddr", 32'(mem_rAddr), 32'd8);
        @(posedge clk); #1;
        check("wrap_rsp_data", 32'(rsp_data), 32'h10);
        @(negedge clk);
        for (int i = 0; i < 4; i++) setReq(i, 1'b1, 1'b0, 4'(8 + i), 8'h00);
        #1;
        check("ptr2_ready", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        check("ptr2_rsp_valid", 32'(rsp_valid), 32'b0100);
        check("ptr2_rsp_data", 32'(rsp_data), 32'h12);

        // Clock enable low in RUN: no grants, response and pointer hold.
        @(negedge clk);
        clk_en = 1'b0;
        #1;
        check("off_ready", 32'(req_ready), 32'h0);
        check("off_wEn", 32'(mem_wEn), 32'h0);
        check("off_rEn", 32'(mem_rEn), 32'h0);
        @(posedge clk); #1;
        check("off_rsp_valid", 32'(rsp_valid), 32'b0100);
        check("off_rsp_data", 32'(rsp_data), 32'h12);
        @(negedge clk);
        clk_en = 1'b1;
        #1;
        check("on_ready", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        check("on_rsp_data", 32'(rsp_data), 32'h13);

        // Reset during a pending read: access aborts, sweep restarts at 0.
        @(negedge clk);
        req_valid = '0;
        setReq(0, 1'b1, 1'b0, 4'd8, 8'h00);
        #1;
        check("pend_ready", 32'(req_ready), 32'b0001);
        check("pend_rEn", 32'(mem_rEn), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_rEn", 32'(mem_rEn), 32'h0);
        check("abort_ready", 32'(req_ready), 32'h0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        check("abort_init_done", 32'(init_done), 32'h0);
        @(posedge clk); #1;
        check("abort_rsp_valid2", 32'(rsp_valid), 32'h0);
        check("abort_rsp_data", 32'(rsp_data), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check("restart_wEn", 32'(mem_wEn), 32'h1);
            check("restart_wAddr", 32'(mem_wAddr), 32'(i));
            check("restart_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
            check("restart_rsp_valid", 32'(rsp_valid), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
